// File: rtl/constantin_refresh_ctrl_if.sv
// Read port between the constantin refresh sequencer (master) and the constant source (slave).
interface constantin_refresh_ctrl_if #(
  parameter int IDX_W = 3,
  parameter int VAL_W = 64
);
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [IDX_W-1:0] rd_req_idx;
  logic             rd_resp_valid;
  logic [VAL_W-1:0] rd_resp_data;
  logic             rd_resp_err;

  modport master (
    output rd_req_valid, rd_req_idx,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err
  );

  modport slave (
    input  rd_req_valid, rd_req_idx,
    output rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err
  );
endinterface

// File: rtl/constantin_refresh_ctrl.sv
// Sweeps the constantin constant bank over a req/resp read port and holds the latest slot values.
// Sweeps start at reset release, on refresh_req, or from the optional idle-period timer.
module constantin_refresh_ctrl #(
  parameter int               NUM_CONST      = 8,
  parameter int               IDX_W          = 3,
  parameter int               VAL_W          = 64,
  parameter logic [VAL_W-1:0] DEFAULT_VAL    = '0,
  parameter int               REFRESH_PERIOD = 1024,
  parameter int               TIMEOUT        = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         refresh_req,
  constantin_refresh_ctrl_if.master    rd,
  output logic [NUM_CONST*VAL_W-1:0]   values,
  output logic [NUM_CONST-1:0]         value_update,
  output logic                         busy,
  output logic                         sweep_done,
  output logic [NUM_CONST-1:0]         err_mask
);
  localparam int PCNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CONST - 1);
  localparam bit                PERIODIC  = (REFRESH_PERIOD != 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              req_valid;
  logic              pending;
  logic [PCNT_W-1:0] pcnt;
  logic [TCNT_W-1:0] tcnt;
  logic [VAL_W-1:0]  slot_q [NUM_CONST];

  logic start_sweep;
  logic slot_end;

  // Timer expiry and a queued request are folded together so they yield a single sweep.
  assign start_sweep = refresh_req | pending | (PERIODIC && (pcnt == PCNT_LAST));
  assign slot_end    = rd.rd_resp_valid | (tcnt == TCNT_LAST);

  assign rd.rd_req_valid = req_valid;
  assign rd.rd_req_idx   = idx;

  for (genvar g = 0; g < NUM_CONST; g++) begin : g_values
    assign values[g*VAL_W +: VAL_W] = slot_q[g];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= REQ;
      idx          <= '0;
      req_valid    <= 1'b0;
      pending      <= 1'b0;
      pcnt         <= '0;
      tcnt         <= '0;
      busy         <= 1'b1;
      sweep_done   <= 1'b0;
      value_update <= '0;
      err_mask     <= '0;
      for (int i = 0; i < NUM_CONST; i++) slot_q[i] <= DEFAULT_VAL;
    end else begin
      sweep_done   <= 1'b0;
      value_update <= '0;
      case (state)
        IDLE: begin
          if (start_sweep) begin
            state     <= REQ;
            idx       <= '0;
            req_valid <= 1'b1;
            busy      <= 1'b1;
            pending   <= 1'b0;
            pcnt      <= '0;
            err_mask  <= '0;
          end else if (PERIODIC) begin
            pcnt <= pcnt + 1'b1;
          end
        end
        REQ: begin
          if (refresh_req) pending <= 1'b1;
          if (req_valid && rd.rd_req_ready) begin
            state     <= WAIT;
            req_valid <= 1'b0;
            tcnt      <= '0;
          end else begin
            req_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (refresh_req) pending <= 1'b1;
          if (slot_end) begin
            // A response arriving on the expiry cycle still counts as a response.
            if (rd.rd_resp_valid && !rd.rd_resp_err) begin
              slot_q[idx] <= rd.rd_resp_data;
              if (rd.rd_resp_data != slot_q[idx]) value_update[idx] <= 1'b1;
            end else begin
              err_mask[idx] <= 1'b1;
            end
            if (idx == IDX_LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              sweep_done <= 1'b1;
            end else begin
              state     <= REQ;
              idx       <= idx + 1'b1;
              req_valid <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_constantin_refresh_ctrl.sv
// Bench for constantin_refresh_ctrl: the bench plays the constant source and tracks expected slot state.
module tb_constantin_refresh_ctrl;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int VW = 64;
  localparam int RP = 32;
  localparam int TO = 15;

  logic            clock = 1'b0;
  logic            reset;
  logic            refresh_req;
  logic [N*VW-1:0] values;
  logic [N-1:0]    value_update;
  logic            busy;
  logic            sweep_done;
  logic [N-1:0]    err_mask;

  constantin_refresh_ctrl_if #(.IDX_W(IW), .VAL_W(VW)) rif ();

  constantin_refresh_ctrl #(
    .NUM_CONST      (N),
    .IDX_W          (IW),
    .VAL_W          (VW),
    .DEFAULT_VAL    ('0),
    .REFRESH_PERIOD (RP),
    .TIMEOUT        (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .refresh_req  (refresh_req),
    .rd           (rif),
    .values       (values),
    .value_update (value_update),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .err_mask     (err_mask)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state: what each slot should hold, and the source's behaviour per slot.
  logic [VW-1:0] exp_vals [N];
  logic [N-1:0]  exp_err;
  logic [VW-1:0] src_val  [N];
  bit            src_err  [N];
  bit            src_silent [N];
  int            upd_cnt  [N];
  int            done_cnt;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] slot(input int i);
    return values[i*VW +: VW];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (value_update[i] === 1'b1) upd_cnt[i]++;
    if (sweep_done === 1'b1) done_cnt++;
  endtask

  task automatic start_refresh(input string tag);
    refresh_req = 1'b1;
    step();
    refresh_req = 1'b0;
    check($sformatf("%s_req_latency", tag), VW'(rif.rd_req_valid), VW'(1));
  endtask

  // Acts as the source for one sweep; stop_at >= 0 abandons the sweep right after that slot is accepted.
  task automatic run_sweep(input string tag, input bit rnd, input int stop_at, input logic [N-1:0] req_pulse_at);
    logic [N-1:0] exp_upd;
    int w;
    exp_upd  = '0;
    exp_err  = '0;
    done_cnt = 0;
    for (int i = 0; i < N; i++) upd_cnt[i] = 0;
    for (int i = 0; i < N; i++) begin
      int stall;
      int dly;
      stall = rnd ? int'($urandom_range(0, 2)) : 0;
      dly   = rnd ? int'($urandom_range(0, 3)) : 0;
      if (req_pulse_at[i]) begin
        refresh_req = 1'b1;
        step();
        refresh_req = 1'b0;
      end
      w = 0;
      while (rif.rd_req_valid !== 1'b1 && w < 64) begin
        step();
        w++;
      end
      if (w >= 64) begin
        check($sformatf("%s_req_wait%0d", tag, i), VW'(rif.rd_req_valid), VW'(1));
        return;
      end
      repeat (stall) step();
      check($sformatf("%s_idx%0d", tag, i), VW'(rif.rd_req_idx), VW'(i));
      rif.rd_req_ready = 1'b1;
      step();
      rif.rd_req_ready = 1'b0;
      check($sformatf("%s_wait_novalid%0d", tag, i), VW'(rif.rd_req_valid), VW'(0));
      if (i == stop_at) return;
      if (src_silent[i]) begin
        w = 0;
        do begin
          step();
          w++;
        end while (rif.rd_req_valid !== 1'b1 && sweep_done !== 1'b1 && w < 40);
        check($sformatf("%s_timeout_len%0d", tag, i), VW'(w), VW'(TO));
        if (i < N - 1) begin
          rif.rd_resp_valid = 1'b1;
          rif.rd_resp_data  = ~exp_vals[i];
          rif.rd_resp_err   = 1'b0;
          step();
          rif.rd_resp_valid = 1'b0;
          check($sformatf("%s_late_ignored%0d", tag, i), slot(i), exp_vals[i]);
        end
      end else begin
        repeat (dly) step();
        rif.rd_resp_valid = 1'b1;
        rif.rd_resp_data  = src_val[i];
        rif.rd_resp_err   = src_err[i];
        step();
        rif.rd_resp_valid = 1'b0;
        rif.rd_resp_err   = 1'b0;
        if (!src_err[i]) begin
          if (src_val[i] != exp_vals[i]) exp_upd[i] = 1'b1;
          exp_vals[i] = src_val[i];
        end
        check($sformatf("%s_value%0d", tag, i), slot(i), exp_vals[i]);
        check($sformatf("%s_upd_now%0d", tag, i), VW'(value_update[i]), VW'(exp_upd[i]));
      end
      exp_err[i] = src_err[i] | src_silent[i];
      check($sformatf("%s_errbit%0d", tag, i), VW'(err_mask[i]), VW'(exp_err[i]));
    end
    check($sformatf("%s_done_pulse", tag), VW'(sweep_done), VW'(1));
    check($sformatf("%s_busy_end", tag), VW'(busy), VW'(0));
    check($sformatf("%s_done_count", tag), VW'(done_cnt), VW'(1));
    check($sformatf("%s_err_mask", tag), VW'(err_mask), VW'(exp_err));
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_final_value%0d", tag, i), slot(i), exp_vals[i]);
      check($sformatf("%s_upd_count%0d", tag, i), VW'(upd_cnt[i]), VW'(exp_upd[i]));
    end
  endtask

  task automatic randomize_source();
    for (int i = 0; i < N; i++) begin
      src_val[i]    = ($urandom_range(0, 3) == 0) ? exp_vals[i] : {$urandom(), $urandom()};
      src_err[i]    = ($urandom_range(0, 7) == 0);
      src_silent[i] = !src_err[i] && ($urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    int w;
    reset              = 1'b1;
    refresh_req        = 1'b0;
    rif.rd_req_ready   = 1'b0;
    rif.rd_resp_valid  = 1'b0;
    rif.rd_resp_data   = '0;
    rif.rd_resp_err    = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_vals[i]   = '0;
      src_val[i]    = VW'(100 + i);
      src_err[i]    = 1'b0;
      src_silent[i] = 1'b0;
      upd_cnt[i]    = 0;
    end
    exp_err  = '0;
    done_cnt = 0;

    repeat (3) step();
    check("rst_busy", VW'(busy), VW'(1));
    check("rst_req_valid", VW'(rif.rd_req_valid), VW'(0));
    check("rst_sweep_done", VW'(sweep_done), VW'(0));
    check("rst_err_mask", VW'(err_mask), VW'(0));
    check("rst_value_update", VW'(value_update), VW'(0));
    for (int i = 0; i < N; i++) check($sformatf("rst_value%0d", i), slot(i), '0);
    reset = 1'b0;

    // Initial sweep after reset, zero-wait source returning 100+i.
    run_sweep("init", 1'b0, -1, '0);

    // Identical data: nothing should pulse. Then a single changed slot.
    start_refresh("same");
    run_sweep("same", 1'b0, -1, '0);
    src_val[3] = VW'(7);
    start_refresh("chg3");
    run_sweep("chg3", 1'b0, -1, '0);

    // Slot 5 silent: times out, keeps its value, late response ignored.
    src_silent[5] = 1'b1;
    src_val[5]    = VW'(555);
    start_refresh("tmo5");
    run_sweep("tmo5", 1'b1, -1, '0);
    check("tmo5_mask_value", VW'(err_mask), VW'(8'h20));
    src_silent[5] = 1'b0;
    src_val[5]    = VW'(105);

    // Slot 2 reports an error, then a clean sweep clears the mask.
    src_err[2] = 1'b1;
    src_val[2] = VW'(999);
    start_refresh("err2");
    run_sweep("err2", 1'b1, -1, '0);
    src_err[2] = 1'b0;
    start_refresh("clean");
    run_sweep("clean", 1'b1, -1, '0);
    check("clean_mask_zero", VW'(err_mask), VW'(0));

    // Three requests during a sweep collapse into one extra sweep.
    start_refresh("pend");
    run_sweep("pend", 1'b1, -1, 8'b0010_1010);
    step();
    check("pend_extra_start", VW'(rif.rd_req_valid), VW'(1));
    run_sweep("extra", 1'b1, -1, '0);

    // No further request queued: next sweep comes only from the idle timer.
    w = 0;
    while (rif.rd_req_valid !== 1'b1 && w < 100) begin
      step();
      w++;
      if (w == 10) check("idle_busy_low", VW'(busy), VW'(0));
    end
    check("period_idle_cycles", VW'(w), VW'(RP));
    run_sweep("auto", 1'b1, -1, '0);

    for (int r = 0; r < 4; r++) begin
      randomize_source();
      start_refresh($sformatf("rnd%0d", r));
      run_sweep($sformatf("rnd%0d", r), 1'b1, -1, '0);
    end

    // Reset while waiting on slot 4 with a queued request pending.
    for (int i = 0; i < N; i++) begin
      src_val[i]    = {$urandom(), $urandom()};
      src_err[i]    = 1'b0;
      src_silent[i] = 1'b0;
    end
    start_refresh("mid");
    run_sweep("mid", 1'b1, 4, 8'b0000_0100);
    step();
    step();
    reset = 1'b1;
    #1;
    check("midrst_req_valid", VW'(rif.rd_req_valid), VW'(0));
    check("midrst_busy", VW'(busy), VW'(1));
    check("midrst_done", VW'(sweep_done), VW'(0));
    check("midrst_err_mask", VW'(err_mask), VW'(0));
    check("midrst_update", VW'(value_update), VW'(0));
    for (int i = 0; i < N; i++) begin
      exp_vals[i] = '0;
      check($sformatf("midrst_value%0d", i), slot(i), '0);
    end
    step();
    step();
    reset = 1'b0;
    run_sweep("post", 1'b1, -1, '0);
    repeat (5) step();
    check("post_no_pending_busy", VW'(busy), VW'(0));
    check("post_no_pending_req", VW'(rif.rd_req_valid), VW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
